// File: rtl/spi_pkg.sv
// spi_pkg: shared word width, FSM states and counter sizing for the SPI slave responder
package spi_pkg;
    localparam int SPI_WORD_W = 32;
    typedef enum logic {ST_IDLE, ST_SHIFT} state_e;
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: multi-flop synchroniser with registered rise/fall detect;
// lvl_o is delayed to stay aligned with the edge pulses.
module spi_slave_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sh_q;
    logic lvl_q, rise_q, fall_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_q   <= '0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sh_q   <= {sh_q[STAGES-2:0], d_i};
            lvl_q  <= sh_q[STAGES-1];
            rise_q <= sh_q[STAGES-1] & ~lvl_q;
            fall_q <= ~sh_q[STAGES-1] & lvl_q;
        end
    end
    assign lvl_o  = lvl_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
endmodule

// File: rtl/spi_slave_responder.sv
// spi_slave_responder: oversampling SPI mode-0 slave, one MOSI word in / one MISO word out per frame.
// Define SPI_SLAVE_FRAME_ERR_EN to add the FRAME_ERR short/overrun frame indicator.
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int WORD_W      = SPI_WORD_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              SPI_SCLK,
    input  logic              SPI_CS,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    output logic              SPI_MISO_OE,
    input  logic [WORD_W-1:0] TX_DATA,
    output logic              TX_ACK,
    output logic [WORD_W-1:0] RX_DATA,
    output logic              RX_VALID,
`ifdef SPI_SLAVE_FRAME_ERR_EN
    output logic              FRAME_ERR,
`endif
    output logic              BUSY
);
    localparam int CW = cnt_w(WORD_W);
    localparam logic [CW-1:0] FULL = CW'(WORD_W);
    localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);

    logic sclk_lvl, sclk_rise, sclk_fall, cs_lvl, cs_rise, cs_fall, mosi_lvl, mosi_rise, mosi_fall;

    spi_slave_sync #(.STAGES(SYNC_STAGES)) u_sclk (.clk_i(CLOCK), .rst_i(RESET), .d_i(SPI_SCLK),
        .lvl_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
    spi_slave_sync #(.STAGES(SYNC_STAGES)) u_cs (.clk_i(CLOCK), .rst_i(RESET), .d_i(SPI_CS),
        .lvl_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));
    spi_slave_sync #(.STAGES(SYNC_STAGES)) u_mosi (.clk_i(CLOCK), .rst_i(RESET), .d_i(SPI_MOSI),
        .lvl_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));

    state_e            state_q, state_d;
    logic              arm_q, arm_d, miso_q, miso_d, ack_q, ack_d, rv_q, rv_d, ovr_q, ovr_d, err_q, err_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0] rx_shr_q, rx_shr_d, tx_shr_q, tx_shr_d, rx_data_q, rx_data_d;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            arm_q     <= 1'b0;
            miso_q    <= 1'b0;
            ack_q     <= 1'b0;
            rv_q      <= 1'b0;
            ovr_q     <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            rx_shr_q  <= '0;
            tx_shr_q  <= '0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            arm_q     <= arm_d;
            miso_q    <= miso_d;
            ack_q     <= ack_d;
            rv_q      <= rv_d;
            ovr_q     <= ovr_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            rx_shr_q  <= rx_shr_d;
            tx_shr_q  <= tx_shr_d;
            rx_data_q <= rx_data_d;
        end
    end

    // CS rise outranks any SCLK edge seen in the same cycle
    always_comb begin
        state_d   = state_q;
        arm_d     = arm_q | cs_lvl;
        miso_d    = miso_q;
        ack_d     = 1'b0;
        rv_d      = 1'b0;
        ovr_d     = ovr_q;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        rx_shr_d  = rx_shr_q;
        tx_shr_d  = tx_shr_q;
        rx_data_d = rx_data_q;
        if (state_q == ST_IDLE) begin
            if (cs_fall && arm_q) begin
                state_d  = ST_SHIFT;
                tx_shr_d = TX_DATA;
                ack_d    = 1'b1;
                cnt_d    = '0;
                miso_d   = TX_DATA[WORD_W-1];
                ovr_d    = 1'b0;
            end
        end else if (cs_rise) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
            err_d   = ovr_q || (cnt_q != '0 && cnt_q != FULL);
        end else if (sclk_rise) begin
            ovr_d     = ovr_q | (cnt_q == FULL);
            rx_shr_d  = (cnt_q == FULL) ? rx_shr_q : {rx_shr_q[WORD_W-2:0], mosi_lvl};
            cnt_d     = (cnt_q == FULL) ? cnt_q : cnt_q + CW'(1);
            rv_d      = (cnt_q == LAST);
            rx_data_d = (cnt_q == LAST) ? {rx_shr_q[WORD_W-2:0], mosi_lvl} : rx_data_q;
        end else if (sclk_fall) begin
            tx_shr_d = tx_shr_q << 1;
            miso_d   = (cnt_q == FULL) ? 1'b0 : tx_shr_q[WORD_W-2];
        end
    end

    assign SPI_MISO    = miso_q;
    assign SPI_MISO_OE = (state_q == ST_SHIFT);
    assign BUSY        = (state_q == ST_SHIFT);
    assign TX_ACK      = ack_q;
    assign RX_VALID    = rv_q;
    assign RX_DATA     = rx_data_q;

    logic unused_sync;
    assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};
`ifdef SPI_SLAVE_FRAME_ERR_EN
    assign FRAME_ERR = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif
endmodule

// File: tb/tb_spi_slave_responder.sv
// tb_spi_slave_responder: directed + random frames checked against a word-level SPI slave model.
module tb_spi_slave_responder;
    localparam int W = 32;
    localparam int HALF = 8;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic CLOCK = 1'b0, RESET = 1'b1, SPI_SCLK = 1'b0, SPI_CS = 1'b1, SPI_MOSI = 1'b0;
    logic [W-1:0] TX_DATA = '0;
    logic SPI_MISO, SPI_MISO_OE, TX_ACK, RX_VALID, BUSY, FRAME_ERR;
    logic [W-1:0] RX_DATA;
    int n_chk = 0, n_fail = 0;
    int n_rv = 0, n_ack = 0, n_err = 0, e_rv = 0, e_ack = 0, e_err = 0;
    logic [W-1:0] e_rx = '0;

    always #5 CLOCK = ~CLOCK;

    spi_slave_responder dut (
        .CLOCK(CLOCK), .RESET(RESET), .SPI_SCLK(SPI_SCLK), .SPI_CS(SPI_CS), .SPI_MOSI(SPI_MOSI),
        .SPI_MISO(SPI_MISO), .SPI_MISO_OE(SPI_MISO_OE), .TX_DATA(TX_DATA), .TX_ACK(TX_ACK),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
`ifdef SPI_SLAVE_FRAME_ERR_EN
        .FRAME_ERR(FRAME_ERR),
`endif
        .BUSY(BUSY)
    );
`ifndef SPI_SLAVE_FRAME_ERR_EN
    assign FRAME_ERR = 1'b0;
`endif

    // pulse counters: a pulse held for two cycles counts twice
    always @(posedge CLOCK) begin
        if (!RESET) begin
            n_rv  += int'(RX_VALID);
            n_ack += int'(TX_ACK);
            n_err += int'(FRAME_ERR);
        end
    end

    initial begin
        #3ms;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int k);
        repeat (k) @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // one frame of n SCLK periods; rst_at >= 0 pulses RESET before that bit's rising edge
    task automatic frame(input logic [63:0] mosi, input int n, input logic [W-1:0] tx,
                         input bit coinc, input int rst_at, input int gap);
        logic [W-1:0] got, em;
        int m, eff;
        bit dead;
        got  = '0;
        dead = 1'b0;
        TX_DATA = tx;
        SPI_CS  = 1'b0;
        cyc(HALF);
        TX_DATA = W'($urandom);
        e_ack++;
        for (int i = 0; i < n; i++) begin
            SPI_MOSI = mosi[n-1-i];
            cyc(HALF);
            if (i == rst_at) begin
                RESET = 1'b1;
                cyc(1);
                chk("rst_mid_rx", RX_DATA, 0);
                chk("rst_mid_busy", BUSY, 0);
                chk("rst_mid_oe", SPI_MISO_OE, 0);
                chk("rst_mid_miso", SPI_MISO, 0);
                RESET = 1'b0;
                dead  = 1'b1;
                e_rx  = '0;
            end
            if (i == 0) begin
                chk("busy_in_frame", BUSY, 1);
                chk("oe_in_frame", SPI_MISO_OE, 1);
            end
            if (i < W && !dead) got[W-1-i] = SPI_MISO;
            if (i >= W) chk("miso_after_word", SPI_MISO, 0);
            SPI_SCLK = 1'b1;
            if (coinc && i == n - 1) SPI_CS = 1'b1;
            cyc(HALF);
            SPI_SCLK = 1'b0;
        end
        cyc(HALF);
        if (dead) begin
            chk("oe_after_reset", SPI_MISO_OE, 0);
            chk("miso_after_reset", SPI_MISO, 0);
        end else begin
            m   = (n < W) ? n : W;
            em  = '1;
            em  = em << (W - m);
            chk("miso_word", got, tx & em);
            eff = coinc ? n - 1 : n;
            if (eff >= W) begin
                e_rv++;
                e_rx = W'(mosi >> (n - W));
            end
            if (FE && eff != 0 && eff != W) e_err++;
        end
        SPI_CS = 1'b1;
        cyc(gap);
    endtask

    task automatic check_all(input string tag);
        cyc(12);
        chk({tag, "_rx_data"}, RX_DATA, e_rx);
        chk({tag, "_rx_valid"}, n_rv, e_rv);
        chk({tag, "_tx_ack"}, n_ack, e_ack);
        chk({tag, "_frame_err"}, n_err, e_err);
    endtask

    initial begin
        int n;
        cyc(3);
        RESET = 1'b0;
        cyc(1);
        chk("reset_miso", SPI_MISO, 0);
        chk("reset_oe", SPI_MISO_OE, 0);
        chk("reset_ack", TX_ACK, 0);
        chk("reset_rx_data", RX_DATA, 0);
        chk("reset_rx_valid", RX_VALID, 0);
        chk("reset_busy", BUSY, 0);
        chk("reset_frame_err", FRAME_ERR, 0);
        cyc(8);

        frame(64'hAAAAAAAE, 32, 32'h12345678, 1'b0, -1, 12);
        check_all("t1_basic");
        frame(64'hBEEF, 16, W'($urandom), 1'b0, -1, 12);
        check_all("t3_short");
        frame({$urandom, $urandom}, 32, 32'h0000FFFF, 1'b0, -1, 4);
        frame({$urandom, $urandom}, 32, 32'hFFFF0000, 1'b0, -1, 12);
        check_all("t2_b2b");
        frame({24'h0, 32'hC0FFEE01, 8'hFF}, 40, W'($urandom), 1'b0, -1, 12);
        check_all("t4_overrun");
        frame({$urandom, $urandom}, 32, W'($urandom), 1'b0, 10, 12);
        check_all("t5_reset");
        frame(64'h0000000F, 32, W'($urandom), 1'b0, -1, 12);
        check_all("t5_recover");
        frame({$urandom, $urandom}, 32, W'($urandom), 1'b1, -1, 12);
        check_all("t6_coincide");

        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 2))
                0: n = W;
                1: n = $urandom_range(1, W - 1);
                default: n = W + $urandom_range(1, 8);
            endcase
            frame({$urandom, $urandom}, n, W'($urandom), 1'b0, -1, $urandom_range(4, 12));
            check_all("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
